// File: rtl/fetch_pkg.sv
// fetch_pkg: opcodes, FSM states and instruction field positions for instr_fetch_seq
package fetch_pkg;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_BZ   = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 6;
  localparam int OP1_MSB = 5;
  localparam int OP1_LSB = 3;
  localparam int OP2_MSB = 2;
  localparam int OP2_LSB = 0;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: program storage with synchronous write and registered read.
// The read register doubles as the sequencer's instruction register, so it resets to 0.
module instr_mem #(
  parameter int AW = 6,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: program-memory sequencer feeding the datapath with JMP/BZ/HALT control flow.
// Define FETCH_RETIRE_CNT_EN to build the saturating retired-instruction counter.
module instr_fetch_seq
  import fetch_pkg::*;
#(
  parameter int PC_W = 6,
  parameter int IW   = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [IW-1:0]   prog_data,
  input  logic            start,
  input  logic            op_ready,
  input  logic            z_in,
  output logic [3:0]      op,
  output logic [2:0]      op1,
  output logic [2:0]      op2,
  output logic            op_valid,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired_cnt
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, target;
  logic zflag_q, zflag_d, alu;
  logic [IW-1:0] ir;
  instr_mem #(.AW(PC_W), .DW(IW)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (prog_we && state_q == S_IDLE),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state_q == S_FETCH),
    .raddr (pc_q),
    .rdata (ir)
  );
  assign op       = ir[OP_MSB:OP_LSB];
  assign op1      = ir[OP1_MSB:OP1_LSB];
  assign op2      = ir[OP2_MSB:OP2_LSB];
  assign target   = PC_W'({op1, op2});
  assign alu      = !(op inside {OP_JMP, OP_BZ, OP_HALT});
  assign op_valid = state_q == S_EXEC && alu;
  assign pc       = pc_q;
  assign busy     = state_q == S_FETCH || state_q == S_EXEC;
  assign halted   = state_q == S_HALT;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    zflag_d = zflag_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) begin
        state_d = S_FETCH;
        pc_d    = '0;
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: if (op == OP_JMP) begin
        state_d = S_FETCH;
        pc_d    = target;
      end else if (op == OP_BZ) begin
        state_d = S_FETCH;
        pc_d    = zflag_q ? target : pc_q + 1'b1;
      end else if (op == OP_HALT) begin
        state_d = S_HALT;
      end else if (op_ready) begin
        state_d = S_FETCH;
        zflag_d = z_in;
        pc_d    = pc_q + 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zflag_q <= zflag_d;
    end
`ifdef FETCH_RETIRE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic start_ok, done;
  assign start_ok = start && (state_q == S_IDLE || state_q == S_HALT);
  assign done     = state_q == S_EXEC && (!alu || op_ready);
  assign cnt_d    = start_ok ? 16'd0 : (done && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = '0;
`endif
endmodule
